// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg: segment codes, width helper and BCD decode
// shared by the BCD counter and its seven-segment decoder.
package seven_seg_pkg;

  // Active-low cathodes, bit 6 = g ... bit 0 = a.
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam int TICK_DIV_DEF = 100_000_000;
  localparam int SCAN_DIV_DEF = 100_000;
  localparam int TICK_W_DEF   = $clog2(TICK_DIV_DEF);
  localparam int SCAN_W_DEF   = $clog2(SCAN_DIV_DEF);

  typedef enum logic {
    DIR_DN = 1'b0,
    DIR_UP = 1'b1
  } dir_e;

  // Counter width for a modulus n, never narrower than 1 bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [6:0] bcd_to_seg(
    input logic [3:0] nib
  );
    logic [6:0] s;
    unique case (nib)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seven_seg_decoder.sv
// seven_seg_decoder: combinational BCD nibble to cathode pattern.
// Ports: nib (BCD digit), blank (force dark) -> seg (active-low).
module seven_seg_decoder
  import seven_seg_pkg::*;
(
  input  logic [3:0] nib,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = bcd_to_seg(nib);
    if (blank) seg = SEG_BLANK;
  end

endmodule

// File: rtl/seven_seg_bcd_counter.sv
// seven_seg_bcd_counter: multi-digit BCD up/down counter with
// prescaled stepping, load, wrap pulse and multiplexed display.
// Ports: Clk, Clr_n (async low), En, Up, Load, LoadVal[4*DIGITS]
//        -> Seg[6:0] (active-low), An[DIGITS] (active-low), Wrap.
module seven_seg_bcd_counter
  import seven_seg_pkg::*;
#(
  parameter int TICK_DIV = 100_000_000,
  parameter int SCAN_DIV = 100_000,
  parameter int DIGITS   = 4,
  parameter bit BLANK_LZ = 1'b0
) (
  input  logic                Clk,
  input  logic                Clr_n,
  input  logic                En,
  input  logic                Up,
  input  logic                Load,
  input  logic [4*DIGITS-1:0] LoadVal,
  output logic [6:0]          Seg,
  output logic [DIGITS-1:0]   An,
  output logic                Wrap
);

  localparam int TW = cnt_w(TICK_DIV);
  localparam int SW = cnt_w(SCAN_DIV);
  localparam int IW = cnt_w(DIGITS);

  localparam logic [TW-1:0] TICK_LAST =
    TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST =
    SW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST =
    IW'(DIGITS - 1);

  // Prescaler
  logic [TW-1:0] pre_q;
  logic          tick;

  assign tick = En && (pre_q == TICK_LAST);

  always_ff @(posedge Clk or negedge Clr_n) begin
    if (!Clr_n) begin
      pre_q <= '0;
    end else if (Load || tick) begin
      pre_q <= '0;
    end else if (En) begin
      pre_q <= pre_q + TW'(1);
    end
  end

  // Digit chain
  dir_e dir;
  assign dir = dir_e'(Up);

  logic [3:0]        dig [DIGITS];
  // step[i]: carry (up) or borrow (down) arriving at digit i.
  logic [DIGITS:0]   step;
  // lz[i]: digit i and every digit above it are zero.
  logic [DIGITS:0]   lz;
  logic [DIGITS-1:0] blank;

  assign step[0]    = tick;
  assign lz[DIGITS] = 1'b1;

  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    logic [3:0] q;
    logic [3:0] nxt;
    logic [3:0] ld_nib;
    logic       at_end;

    assign ld_nib = LoadVal[4*i +: 4];
    assign at_end = (dir == DIR_UP) ?
                    (q == 4'd9) : (q == 4'd0);
    assign step[i+1] = step[i] & at_end;

    always_comb begin
      nxt = q;
      if (step[i]) begin
        if (at_end) begin
          nxt = (dir == DIR_UP) ? 4'd0 : 4'd9;
        end else if (dir == DIR_UP) begin
          nxt = q + 4'd1;
        end else begin
          nxt = q - 4'd1;
        end
      end
    end

    always_ff @(posedge Clk or negedge Clr_n) begin
      if (!Clr_n) begin
        q <= '0;
      end else if (Load) begin
        // Non-BCD nibbles load as zero.
        q <= (ld_nib > 4'd9) ? 4'd0 : ld_nib;
      end else begin
        q <= nxt;
      end
    end

    assign dig[i]   = q;
    assign lz[i]    = lz[i+1] & (q == 4'd0);
    assign blank[i] = BLANK_LZ && (i > 0) && lz[i];
  end

  // A carry/borrow out of the top digit is a full-range wrap.
  always_ff @(posedge Clk or negedge Clr_n) begin
    if (!Clr_n) begin
      Wrap <= 1'b0;
    end else begin
      Wrap <= !Load && step[DIGITS];
    end
  end

  // Scan divider and digit index
  logic [SW-1:0] scn_q;
  logic [IW-1:0] idx_q;

  always_ff @(posedge Clk or negedge Clr_n) begin
    if (!Clr_n) begin
      scn_q <= '0;
      idx_q <= '0;
    end else if (scn_q == SCAN_LAST) begin
      scn_q <= '0;
      idx_q <= (idx_q == IDX_LAST) ?
               '0 : idx_q + IW'(1);
    end else begin
      scn_q <= scn_q + SW'(1);
    end
  end

  // Display
  logic [6:0] seg_d;

  seven_seg_decoder u_dec (
    .nib   (dig[idx_q]),
    .blank (blank[idx_q]),
    .seg   (seg_d)
  );

  always_ff @(posedge Clk or negedge Clr_n) begin
    if (!Clr_n) begin
      Seg <= SEG_BLANK;
      An  <= '1;
    end else begin
      Seg <= seg_d;
      An  <= ~(DIGITS'(1) << idx_q);
    end
  end

endmodule

// File: tb/tb_seven_seg_bcd_counter.sv
// tb_seven_seg_bcd_counter: scoreboard bench, integer reference
// model, plain and leading-zero-blanked instances side by side.
module tb_seven_seg_bcd_counter;

  localparam int T = 4;
  localparam int S = 3;
  localparam int D = 2;

  logic       Clk   = 1'b0;
  logic       Clr_n = 1'b0;
  logic       En    = 1'b0;
  logic       Up    = 1'b1;
  logic       Load  = 1'b0;
  logic [7:0] LoadVal = '0;

  logic [6:0] Seg, Seg_b;
  logic [1:0] An, An_b;
  logic       Wrap, Wrap_b;

  seven_seg_bcd_counter #(
    .TICK_DIV (T),
    .SCAN_DIV (S),
    .DIGITS   (D),
    .BLANK_LZ (1'b0)
  ) dut (
    .Clk     (Clk),
    .Clr_n   (Clr_n),
    .En      (En),
    .Up      (Up),
    .Load    (Load),
    .LoadVal (LoadVal),
    .Seg     (Seg),
    .An      (An),
    .Wrap    (Wrap)
  );

  seven_seg_bcd_counter #(
    .TICK_DIV (T),
    .SCAN_DIV (S),
    .DIGITS   (D),
    .BLANK_LZ (1'b1)
  ) dut_b (
    .Clk     (Clk),
    .Clr_n   (Clr_n),
    .En      (En),
    .Up      (Up),
    .Load    (Load),
    .LoadVal (LoadVal),
    .Seg     (Seg_b),
    .An      (An_b),
    .Wrap    (Wrap_b)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [1:0] an;
    logic [6:0] seg;
    logic [6:0] segb;
    logic       wrap;
  } exp_t;

  exp_t q[$];
  exp_t me;
  int   total = 0;
  int   bad   = 0;

  int m_val   = 0;
  int m_ph    = 0;
  int m_edges = 0;

  logic [6:0] segt [10] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

  function automatic int pow10(input int i);
    int p = 1;
    for (int k = 0; k < i; k++) p = p * 10;
    return p;
  endfunction

  function automatic logic [6:0] seg_of(
    input int v, input int i, input bit blz
  );
    int p = pow10(i);
    if (blz && i > 0 && v < p) return 7'h7F;
    return segt[(v / p) % 10];
  endfunction

  function automatic int nib(input logic [3:0] n);
    return (n > 4'd9) ? 0 : int'(n);
  endfunction

  task automatic chk(
    input string nm,
    input logic [15:0] act,
    input logic [15:0] exp
  );
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @%0t: got %h want %h",
               nm, $time, act, exp);
    end
  endtask

  // Monitor: one expectation per clock edge out of reset.
  initial begin
    forever begin
      @(posedge Clk);
      #1;
      if (q.size() > 0) begin
        me = q.pop_front();
        chk("an",     An,     me.an);
        chk("seg",    Seg,    me.seg);
        chk("wrap",   Wrap,   me.wrap);
        chk("an_b",   An_b,   me.an);
        chk("seg_b",  Seg_b,  me.segb);
        chk("wrap_b", Wrap_b, me.wrap);
      end
    end
  end

  // Drive one cycle and predict the outputs after its edge.
  task automatic cyc(
    input bit en, input bit up,
    input bit ld, input logic [7:0] lv
  );
    exp_t e;
    int   ix;
    bit   tk;
    bit   w;
    @(negedge Clk);
    En = en; Up = up; Load = ld; LoadVal = lv;
    ix     = (m_edges / S) % D;
    e.an   = ~(2'b01 << ix);
    e.seg  = seg_of(m_val, ix, 1'b0);
    e.segb = seg_of(m_val, ix, 1'b1);
    tk = en && (m_ph == T - 1);
    w  = 1'b0;
    if (ld) begin
      m_val = nib(lv[7:4]) * 10 + nib(lv[3:0]);
      m_ph  = 0;
    end else begin
      if (en) m_ph = (m_ph + 1) % T;
      if (tk && up) begin
        w     = (m_val == 99);
        m_val = (m_val + 1) % 100;
      end else if (tk) begin
        w     = (m_val == 0);
        m_val = (m_val + 99) % 100;
      end
    end
    m_edges++;
    e.wrap = w;
    q.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge Clk);
    #2;
    Clr_n = 1'b0;
    Load  = 1'b0;
    En    = 1'b0;
    #1;
    chk("rst_an",    An,     2'b11);
    chk("rst_seg",   Seg,    7'h7F);
    chk("rst_wrap",  Wrap,   1'b0);
    chk("rst_an_b",  An_b,   2'b11);
    chk("rst_seg_b", Seg_b,  7'h7F);
    m_val   = 0;
    m_ph    = 0;
    m_edges = 0;
    @(posedge Clk);
    #2;
    Clr_n = 1'b1;
  endtask

  initial begin
    do_reset();
    repeat (40) cyc(1, 1, 0, 8'h00);

    cyc(0, 1, 1, 8'h99);
    repeat (8) cyc(1, 1, 0, 8'h00);

    cyc(1, 0, 1, 8'h00);
    repeat (8) cyc(1, 0, 0, 8'h00);

    while (m_ph != T - 1) cyc(1, 1, 0, 8'h00);
    cyc(1, 1, 1, 8'h37);
    repeat (6) cyc(1, 1, 0, 8'h00);
    cyc(1, 1, 1, 8'h5C);
    repeat (6) cyc(1, 1, 0, 8'h00);

    cyc(1, 1, 1, 8'h42);
    cyc(1, 1, 0, 8'h00);
    repeat (10) cyc(0, 0, 0, 8'h00);
    repeat (12) cyc(1, 1, 0, 8'h00);

    cyc(1, 1, 1, 8'h05);
    repeat (8) cyc(0, 1, 0, 8'h00);

    repeat (400) begin
      cyc($urandom_range(0, 3) != 0,
          1'($urandom_range(0, 1)),
          $urandom_range(0, 15) == 0,
          8'($urandom));
    end

    repeat (2) cyc(1, 1, 0, 8'h00);
    do_reset();
    repeat (24) cyc(1, 0, 0, 8'h00);

    @(posedge Clk);
    #3;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seven_seg_bcd_counter.md
# seven_seg_bcd_counter

- Parametrised multi-digit BCD up/down counter with time-multiplexed seven-segment drive.
- An internal prescaler steps the count; a scan divider cycles the anode strobes.
- Adds load, enable, direction, wrap flag and optional leading-zero blanking.
- Sits between the board clock/switches and the seven-segment display pins, and replaces the single-digit fixed-anode counter.

## Interface
- TICK_DIV, 100_000_000: clocks per count step (1 Hz at 100 MHz); ≥2.
- SCAN_DIV, 100_000: clocks per digit scan slot; ≥2.
- DIGITS, 4: number of BCD digits / anodes; 1..8.
- BLANK_LZ, 0: 1 = blank leading zero digits (digit 0 never blanked).
- Clk  in  1  system clock, rising edge.
- Clr_n  in  1  reset. One clock; reset is asynchronous and active-low.
- En  in  1  count enable; 0 freezes prescaler and count.
- Up  in  1  direction, 1 = up, 0 = down; sampled at each tick.
- Load  in  1  synchronous load of LoadVal, 1-cycle pulse or level.
- LoadVal  in  4*DIGITS  BCD digits, digit 0 in [3:0].
- Seg  out  7  cathodes, active-low, Seg[6]=g … Seg[0]=a.
- An  out  DIGITS  anodes, active-low one-hot.
- Wrap  out  1  one-cycle pulse on full-range wrap.

## Operation
- **Prescaler:** counts 0..TICK_DIV-1 while En=1; terminal value → 0 with internal tick=1 for that cycle. Holds when En=0. Cleared by Load.
- **Load priority:**
  - Load=1 → digits ← LoadVal; any nibble >9 loads as 0.
  - Tick in the same cycle is discarded; Wrap=0.
- **Counting on a tick (no Load):**
  - Up=1: digit 0 increments; 9→0 carries into the next digit.
  - Up=0: 0→9 borrows from the next digit.
- **Wrap:**
  - All-9s up → all-0s, Wrap=1.
  - All-0s down → all-9s, Wrap=1.
  - Otherwise Wrap=0.
- **Scan:**
  - Free-running divider 0..SCAN_DIV-1, independent of En/Load. At its terminal count, scan index advances 0→1→…→DIGITS-1→0.
  - DIGITS=1: index stays 0 and An[0]=0 permanently after the first slot.
- **Display:**
  - An = ~(1<<index).
  - Seg = decode(digit[index]): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000; blank=1111111.
  - BLANK_LZ=1: digit i>0 is blanked if it and every digit above it are 0.
- **Reset (Clr_n=0, any time, immediate):**
  - Prescaler, scan divider, index and digits = 0.
  - Wrap=0, An = all 1s (dark), Seg = 1111111.

## Timing
- Seg/An are registered: they reflect the index and digits of the previous cycle (1-cycle latency).
- Count changes on the clock edge where tick=1. Wrap is asserted in the cycle after that edge, for exactly 1 cycle, aligned with the new digit values.
- Load takes effect at the next edge; displayed value follows 1 cycle later.
- After Clr_n deasserts:
  - First tick occurs TICK_DIV cycles later (with En=1).
  - First anode is driven on the edge after the first rising Clk.
- En deassert mid-period: the prescaler value is held; on resume it continues, it is not restarted.
- Up change between ticks has no effect until the next tick.

## Structure
- **Package seven_seg_pkg:**
  - Segment constants SEG_0..SEG_9 and SEG_BLANK.
  - Function bcd_to_seg(nibble) returning SEG_BLANK for >9.
  - Localparam widths via $clog2(TICK_DIV) and $clog2(SCAN_DIV).
- **Sub-module seven_seg_decoder:** combinational nibble+blank → Seg. The top registers its output.
- Digit counter chain is a generate loop over DIGITS.

## Test plan
Bench parameters: TICK_DIV=4, SCAN_DIV=3, DIGITS=2, BLANK_LZ=0.
- **Reset release, En=1, Up=1:** after 4 ticks (16 clk) digits=04. Display scans An=10→01 every 3 clk, with Seg=1000000 on digit 1 and 0011001 on digit 0.
- **Wrap up:** Load 99, Up=1, one tick → digits=00, Wrap high exactly 1 cycle.
- **Wrap down:** Load 00, Up=0, one tick → 99 and Wrap pulse.
- **Load vs tick:** Load LoadVal=8'h37 on the tick cycle → digits=37, no increment, Wrap=0. Nibble 0xC loads as 0.
- **En=0 for 10 cycles mid-period:** count unchanged, and the next tick arrives after the remaining prescaler cycles only.
- **Async reset / blanking:**
  - Clr_n pulsed low mid-scan → An=11 and Seg=1111111 immediately, digits=00.
  - With BLANK_LZ=1 and value 05, digit 1 shows 1111111.
